// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: sequencer state encoding and the primary
// opcodes recognised by both the stage sequencer and main_control.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALTED
  } seq_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // True for opcodes that continue past DECODE into the execute stage
  function automatic logic is_exec_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/stage_seq_perf.sv
// Performance counters for the stage sequencer: busy cycles, retired
// instructions and memory stall cycles. All counters wrap naturally.
// Only present when STAGE_SEQ_PERF_EN is defined; without it this file is empty.
`ifdef STAGE_SEQ_PERF_EN
module stage_seq_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             busy,
  input  logic             retire,
  input  logic             stall,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Count events each cycle; reset or an accepted start zeroes everything
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy)   cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      if (stall)  stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer for the MIPS datapath. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, one stage enable per cycle, waits in MEM
// for the data memory (with a timeout) and strobes PC update and retire.
// Optional macro STAGE_SEQ_PERF_EN adds cycle/instruction/stall counters.
module stage_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             mem_req,
  output logic             pc_write,
  output logic             retire,
  output logic             busy,
  output logic             halted,
  output logic             err
`ifdef STAGE_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  // The wait counter is 4 bits, so the timeout must fit in 1..15
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 15 || CNT_W < 1) begin : g_param_check
    $fatal(1, "stage_sequencer: MEM_TIMEOUT must be 1..15 and CNT_W at least 1");
  end

  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  seq_state_t state;
  logic [5:0] op_q;
  logic [3:0] wait_cnt;
  logic       err_q;
  logic       start_go;
  logic       mem_timeout;

  assign start_go    = start && ((state == IDLE) || (state == HALTED));
  // Timeout fires in the MEM cycle that would bring the wait count to MEM_TIMEOUT;
  // an ack in that same cycle takes priority
  assign mem_timeout = (state == MEM) && !mem_ack && (wait_cnt == TIMEOUT_LAST);

  // Main sequencing FSM with latched opcode, MEM wait counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          if (start_go) begin
            state    <= FETCH;
            err_q    <= 1'b0;
            wait_cnt <= '0;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          op_q <= opcode;
          if (opcode == OP_HALT) begin
            state <= HALTED;
          end else if (is_exec_op(opcode)) begin
            state <= EXEC;
          end else begin
            err_q <= 1'b1;
            state <= FETCH;
          end
        end
        EXEC: begin
          if (op_q == OP_RTYPE) begin
            state <= WB;
          end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
            state <= MEM;
          end else begin
            state <= FETCH;
          end
        end
        MEM: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            state    <= (op_q == OP_LW) ? WB : FETCH;
          end else if (mem_timeout) begin
            wait_cnt <= '0;
            err_q    <= 1'b1;
            state    <= FETCH;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        WB: state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage enables from state alone; pc_write/retire also look at opcode and ack
  always_comb begin
    if_en    = 1'b0;
    id_en    = 1'b0;
    ex_en    = 1'b0;
    mem_en   = 1'b0;
    wb_en    = 1'b0;
    mem_req  = 1'b0;
    pc_write = 1'b0;
    retire   = 1'b0;
    case (state)
      FETCH: if_en = 1'b1;
      DECODE: begin
        id_en = 1'b1;
        if (opcode == OP_HALT) begin
          retire = 1'b1;
        end else if (!is_exec_op(opcode)) begin
          retire   = 1'b1;
          pc_write = 1'b1;
        end
      end
      EXEC: begin
        ex_en = 1'b1;
        if (op_q == OP_BEQ) begin
          retire   = 1'b1;
          pc_write = 1'b1;
        end
      end
      MEM: begin
        mem_en  = 1'b1;
        mem_req = 1'b1;
        if ((mem_ack && (op_q == OP_SW)) || mem_timeout) begin
          retire   = 1'b1;
          pc_write = 1'b1;
        end
      end
      WB: begin
        wb_en    = 1'b1;
        retire   = 1'b1;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state != IDLE) && (state != HALTED);
  assign halted = (state == HALTED);
  assign err    = err_q;

`ifdef STAGE_SEQ_PERF_EN
  stage_seq_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_go),
    .busy     (busy),
    .retire   (retire),
    .stall    ((state == MEM) && !mem_ack),
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt),
    .stall_cnt(stall_cnt)
  );
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a table of instructions with
// expected retire latency, pc_write, MEM request length and sticky error,
// checked through a scoreboard, plus hand sequences for reset corner cases.
module tb_stage_sequencer;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] opcode;
  logic       mem_ack;
  logic       if_en, id_en, ex_en, mem_en, wb_en;
  logic       mem_req, pc_write, retire, busy, halted, err;
`ifdef STAGE_SEQ_PERF_EN
  logic [CNT_W-1:0] cycle_cnt, instr_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  stage_sequencer #(
    .MEM_TIMEOUT(15),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .opcode   (opcode),
    .mem_ack  (mem_ack),
    .if_en    (if_en),
    .id_en    (id_en),
    .ex_en    (ex_en),
    .mem_en   (mem_en),
    .wb_en    (wb_en),
    .mem_req  (mem_req),
    .pc_write (pc_write),
    .retire   (retire),
    .busy     (busy),
    .halted   (halted),
    .err      (err)
`ifdef STAGE_SEQ_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    string      name;
    bit         new_prog;
    logic [5:0] op;
    int         w;
    int         exp_lat;
    logic       exp_pcw;
    int         exp_mreq;
    bit         err_set;
    bit         is_halt;
  } vec_t;

  typedef struct {
    string name;
    int    lat;
    logic  pcw;
    int    mreq;
    bit    err;
    bit    halt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   err_model = 1'b0;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [10:0] allOutputs();
    return {if_en, id_en, ex_en, mem_en, wb_en, mem_req, pc_write, retire, busy, halted, err};
  endfunction

  task automatic addVec(input string name, input bit new_prog, input logic [5:0] op, input int w,
                        input int lat, input logic pcw, input int mreq, input bit err_set, input bit is_halt);
    vec_t v;
    v.name = name; v.new_prog = new_prog; v.op = op; v.w = w; v.exp_lat = lat;
    v.exp_pcw = pcw; v.exp_mreq = mreq; v.err_set = err_set; v.is_halt = is_halt;
    tbl.push_back(v);
  endtask

  // Pulse start from IDLE/HALTED; FETCH must follow with err cleared
  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    err_model = 1'b0;
    checkOutput("start->if_en", if_en, 1);
    checkOutput("start clears err", err, 0);
  endtask

  // Drive one instruction: opcode in FETCH, garbage after DECODE, ack after w MEM cycles
  task automatic applyStimulus(input vec_t v);
    int budget;
    int k;
    exp_t e;
    budget = 0;
    while (!if_en && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!if_en) begin
      checkOutput({v.name, " fetch wait"}, if_en, 1);
      return;
    end
    opcode = v.op;
    err_model = err_model | v.err_set;
    e.name = v.name; e.lat = v.exp_lat; e.pcw = v.exp_pcw;
    e.mreq = v.exp_mreq; e.err = err_model; e.halt = v.is_halt;
    sb.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    opcode = 6'b101010;
    k = 0;
    budget = 0;
    while (!if_en && busy && budget < 60) begin
      if (mem_en) begin
        k++;
        mem_ack = (v.w >= 0) && (k == v.w + 1);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      budget++;
    end
    mem_ack = 1'b0;
    if (budget >= 60) checkOutput({v.name, " completion"}, busy, 0);
  endtask

  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   fetch_cyc = 0;
  int   mreq_cnt = 0;
  bit   post_pending = 1'b0;
  exp_t post_exp;
  exp_t mon_e;

  // Scoreboard monitor: samples on the falling edge, pops an expectation per retire
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (post_pending) begin
        post_pending = 1'b0;
        checkOutput({post_exp.name, " err after"}, err, post_exp.err);
        checkOutput({post_exp.name, " next fetch"}, if_en, !post_exp.halt);
        checkOutput({post_exp.name, " halted"}, halted, post_exp.halt);
      end
      checkOutput("onehot enables", ($countones({if_en, id_en, ex_en, mem_en, wb_en}) <= 1), 1);
      if (if_en) begin
        fetch_cyc = cyc;
        mreq_cnt = 0;
      end
      if (mem_req) mreq_cnt++;
      if (retire) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected retire", retire, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput({mon_e.name, " latency"}, cyc - fetch_cyc + 1, mon_e.lat);
          checkOutput({mon_e.name, " pc_write"}, pc_write, mon_e.pcw);
          checkOutput({mon_e.name, " mem_req cycles"}, mreq_cnt, mon_e.mreq);
          post_exp = mon_e;
          post_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //     name          new op         w   lat pcw mreq errset halt
    addVec("rtype",      1, 6'b000000,  0,  4,  1,  0,   0,     0);
    addVec("beq",        0, 6'b000100,  0,  3,  1,  0,   0,     0);
    addVec("sw_w0",      0, 6'b101011,  0,  4,  1,  1,   0,     0);
    addVec("lw_w3",      0, 6'b100011,  3,  8,  1,  4,   0,     0);
    addVec("halt",       0, 6'b111111,  0,  2,  0,  0,   0,     1);
    addVec("lw_collide", 1, 6'b100011, 14, 19,  1, 15,   0,     0);
    addVec("beq2",       0, 6'b000100,  0,  3,  1,  0,   0,     0);
    addVec("halt2",      0, 6'b111111,  0,  2,  0,  0,   0,     1);
    addVec("illegal",    1, 6'b001111,  0,  2,  1,  0,   1,     0);
    addVec("lw_timeout", 0, 6'b100011, -1, 18,  1, 15,   1,     0);
    addVec("sw_w2",      0, 6'b101011,  2,  6,  1,  3,   0,     0);
    addVec("halt3",      0, 6'b111111,  0,  2,  0,  0,   0,     1);
    addVec("rtype2",     1, 6'b000000,  0,  4,  1,  0,   0,     0);
    addVec("halt4",      0, 6'b111111,  0,  2,  0,  0,   0,     1);

    reset = 1'b1;
    start = 1'b0;
    mem_ack = 1'b0;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs", allOutputs(), 0);
    reset = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle outputs with stray ack", allOutputs(), 0);
    mem_ack = 1'b0;

    mon_en = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].new_prog) pulseStart();
      applyStimulus(tbl[i]);
`ifdef STAGE_SEQ_PERF_EN
      if (i == 4) begin
        checkOutput("perf instr_cnt", instr_cnt, 5);
        checkOutput("perf cycle_cnt", cycle_cnt, 21);
        checkOutput("perf stall_cnt", stall_cnt, 3);
      end
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    checkOutput("scoreboard drained", sb.size(), 0);
    checkOutput("halted at end", halted, 1);
    checkOutput("busy at end", busy, 0);

    // Reset in the second MEM wait cycle of a load, then a late ack
    pulseStart();
    opcode = 6'b100011;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid-MEM first cycle", mem_en, 1);
    @(posedge clk); #1;
    checkOutput("mid-MEM req before reset", mem_req, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid-MEM req dropped", mem_req, 0);
    checkOutput("mid-MEM outputs cleared", allOutputs(), 0);
    reset = 1'b0;
    mem_ack = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      checkOutput("late ack ignored", allOutputs(), 0);
    end
    mem_ack = 1'b0;
`ifdef STAGE_SEQ_PERF_EN
    checkOutput("perf cleared by reset", instr_cnt | cycle_cnt | stall_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
